if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 if_instr  input  32  fetched instruction word.
REQ-004 if_pc_plus4  input  32  PC+4 of fetched instruction.
REQ-005 if_valid  input  1  fetch word valid this cycle.
REQ-006 flush  input  1  branch taken/jump resolved; squash the fetched word.
REQ-007 ex_memread  input  1  instruction one stage downstream is a load.
REQ-008 ex_rt  input  5  destination register of that load.
REQ-009 id_valid  output  1  decode register holds a live instruction.
REQ-010 id_pc_plus4  output  32  registered PC+4.
REQ-011 id_function  output  6; id_rs, id_rt, id_rd, id_shamt  output  5 each  instruction fields.
REQ-012 id_regwrite, id_memtoreg, id_mem_write, id_memread, id_ALUSrc, id_regdst, id_branch, id_jump  output  1 each  control signals.
REQ-013 id_ALUOp  output  2  ALU operation class.
REQ-014 id_illegal  output  1  live instruction has unsupported opcode.
REQ-015 pc_write, ifid_write  output  1 each  0 = hold PC / hold this register.
REQ-016 stall_count  output  16  saturating load-use stall counter.

Function
REQ-017 Pipeline register (instr, pc_plus4, valid) SHALL load if_instr, if_pc_plus4, if_valid on posedge when ifid_write=1 and flush=0.
REQ-018 flush=1 at a posedge SHALL load instr=0, valid=0, regardless of stall; flush has priority over stall.
REQ-019 Fields SHALL be sliced combinationally from the registered word: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], function[5:0].
REQ-020 Control decode (opcode [31:26]): 000000 R-type: regdst, regwrite, ALUOp=10; 100011 lw: ALUSrc, memtoreg, regwrite, memread, ALUOp=00; 101011 sw: ALUSrc, mem_write, ALUOp=00; 000100 beq: branch, ALUOp=01; 001000 addi: ALUSrc, regwrite, ALUOp=00; 000010 j: jump; every unlisted control = 0.
REQ-021 Any other opcode SHALL drive all controls 0 and id_illegal=1 when id_valid=1.
REQ-022 All controls and id_illegal SHALL be 0 when id_valid=0 or a bubble is issued.
REQ-023 Hazard FSM states: RUN, BUBBLE.
REQ-024 Hazard in RUN = id_valid & ex_memread & ex_rt!=0 & (ex_rt==rs | (ex_rt==rt & opcode in {R-type, sw, beq})).
REQ-025 RUN with hazard and flush=0: pc_write=0, ifid_write=0, controls zeroed that cycle, next state BUBBLE, stall_count+1 (saturate at 0xFFFF).
REQ-026 BUBBLE: hazard check ignored, pc_write=1, ifid_write=1, decoded controls driven normally, next state RUN.
REQ-027 flush=1 in any state SHALL force next state RUN and pc_write=1.
REQ-028 No hazard: pc_write=1, ifid_write=1, latency 1 cycle from if_* to id_* outputs.
REQ-029 Only one bubble per load; back-to-back dependent loads each produce exactly one bubble.

Reset
REQ-030 rst=1 SHALL immediately clear instr=0, pc_plus4=0, valid=0, state=RUN, stall_count=0; hence all controls, fields, id_illegal = 0, pc_write=ifid_write=1.
REQ-031 Reset mid-stall SHALL abandon the bubble; first post-reset edge loads normally.

Structure
REQ-032 Opcode constants, ALUOp encodings and FSM state encoding SHALL live in shared package mips_pkg.
REQ-033 Opcode-to-control decode SHALL be sub-module main_control (combinational); this block owns register, FSM, counter.

Verification
REQ-034 Reset then if_instr=0x8C220004 (lw $2,4($1)), if_valid=1 -> next cycle id_memread=1, id_ALUSrc=1, id_rt=2, ALUOp=00.
REQ-035 Registered 0x00430820 (add $1,$2,$3), ex_memread=1, ex_rt=3 -> pc_write=0, ifid_write=0, controls 0, one cycle; next cycle regdst=1, regwrite=1; stall_count=1.
REQ-036 Same as REQ-035 but flush=1 -> no bubble, id_valid=0 next cycle, state RUN, stall_count unchanged.
REQ-037 ex_memread=1, ex_rt=0, rs=0 -> no stall.
REQ-038 if_instr=0xFC000000 -> id_illegal=1, all controls 0; if_valid=0 -> id_valid=0, id_illegal=0.
REQ-039 Force stall_count to 0xFFFF and trigger a hazard -> stays 0xFFFF; assert rst during BUBBLE -> outputs clear asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, control bundle and hazard FSM encoding.
// Imported by the IF/ID register stage and its control decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       mem_write;
        logic       memread;
        logic       alu_src;
        logic       regdst;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_control.sv
// Combinational opcode-to-control decoder for the ID stage.
// Unknown opcodes produce no controls and raise illegal.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            (opcode == OP_LW): begin
                ctrl.alu_src  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            (opcode == OP_SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.aluop     = ALUOP_ADD;
            end
            (opcode == OP_BEQ): begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALUOP_SUB;
            end
            (opcode == OP_ADDI): begin
                ctrl.alu_src  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            (opcode == OP_J): begin
                ctrl.jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field slicing, control decode,
// load-use hazard FSM and a saturating stall counter.
module if_id_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc_plus4,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic        id_valid,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_function,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic        id_regwrite,
    output logic        id_memtoreg,
    output logic        id_mem_write,
    output logic        id_memread,
    output logic        id_ALUSrc,
    output logic        id_regdst,
    output logic        id_branch,
    output logic        id_jump,
    output logic [1:0]  id_ALUOp,
    output logic        id_illegal,
    output logic        pc_write,
    output logic        ifid_write,
    output logic [15:0] stall_count
);

    if_id_t     ifid_q;
    hz_state_t  state_q;
    hz_state_t  state_d;
    logic [15:0] stall_count_q;
    logic [5:0] opcode;
    logic       hazard;
    logic       bubble;
    logic       live;
    ctrl_t      dec_ctrl;
    ctrl_t      out_ctrl;
    logic       dec_illegal;

    assign opcode      = ifid_q.instr[31:26];
    assign id_rs       = ifid_q.instr[25:21];
    assign id_rt       = ifid_q.instr[20:16];
    assign id_rd       = ifid_q.instr[15:11];
    assign id_shamt    = ifid_q.instr[10:6];
    assign id_function = ifid_q.instr[5:0];
    assign id_valid    = ifid_q.valid;
    assign id_pc_plus4 = ifid_q.pc_plus4;
    assign stall_count = stall_count_q;

    main_control u_main_control (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Load-use check only applies while running; a bubble already covers it.
    assign hazard = (state_q == ST_RUN)
                  & ifid_q.valid
                  & ex_memread
                  & (ex_rt != 5'd0)
                  & ((ex_rt == id_rs)
                     | ((ex_rt == id_rt) & reads_rt(opcode)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:    state_d = hazard ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        bubble     = hazard & ~flush;
        pc_write   = ~bubble;
        ifid_write = ~bubble;
    end

    // Flush squashes the word; pc_plus4 is left as-is since valid=0 masks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= '0;
        end else if (flush) begin
            ifid_q.instr <= 32'd0;
            ifid_q.valid <= 1'b0;
        end else if (ifid_write) begin
            ifid_q.instr    <= if_instr;
            ifid_q.pc_plus4 <= if_pc_plus4;
            ifid_q.valid    <= if_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= 16'd0;
        end else if (bubble && (stall_count_q != STALL_MAX)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign live       = ifid_q.valid & ~bubble;
    assign out_ctrl   = live ? dec_ctrl : CTRL_NOP;
    assign id_illegal = live & dec_illegal;

    assign id_regwrite  = out_ctrl.regwrite;
    assign id_memtoreg  = out_ctrl.memtoreg;
    assign id_mem_write = out_ctrl.mem_write;
    assign id_memread   = out_ctrl.memread;
    assign id_ALUSrc    = out_ctrl.alu_src;
    assign id_regdst    = out_ctrl.regdst;
    assign id_branch    = out_ctrl.branch;
    assign id_jump      = out_ctrl.jump;
    assign id_ALUOp     = out_ctrl.aluop;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: driver queues hand-computed
// expectations per cycle, monitor compares them on the falling edge.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        flush;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_function;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        id_regwrite, id_memtoreg, id_mem_write, id_memread;
    logic        id_ALUSrc, id_regdst, id_branch, id_jump;
    logic [1:0]  id_ALUOp;
    logic        id_illegal;
    logic        pc_write, ifid_write;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // {regwrite, memtoreg, mem_write, memread, ALUSrc, regdst, branch, jump}
    localparam logic [7:0] C_R    = 8'b1000_0100;
    localparam logic [7:0] C_LW   = 8'b1101_1000;
    localparam logic [7:0] C_SW   = 8'b0010_1000;
    localparam logic [7:0] C_BEQ  = 8'b0000_0010;
    localparam logic [7:0] C_ADDI = 8'b1000_1000;
    localparam logic [7:0] C_J    = 8'b0000_0001;

    typedef struct {
        string        nm;
        logic [87:0]  e;
    } exp_t;

    exp_t sb[$];

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4),
        .if_valid     (if_valid),
        .flush        (flush),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .id_valid     (id_valid),
        .id_pc_plus4  (id_pc_plus4),
        .id_function  (id_function),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_shamt     (id_shamt),
        .id_regwrite  (id_regwrite),
        .id_memtoreg  (id_memtoreg),
        .id_mem_write (id_mem_write),
        .id_memread   (id_memread),
        .id_ALUSrc    (id_ALUSrc),
        .id_regdst    (id_regdst),
        .id_branch    (id_branch),
        .id_jump      (id_jump),
        .id_ALUOp     (id_ALUOp),
        .id_illegal   (id_illegal),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [87:0] mk(
        input logic        v,
        input logic [7:0]  c,
        input logic [1:0]  a,
        input logic        il,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [5:0]  fn,
        input logic [31:0] pc,
        input logic        pw,
        input logic        iw,
        input logic [15:0] cnt
    );
        return {v, c, a, il, rs, rt, rd, sh, fn, pc, pw, iw, cnt};
    endfunction

    function automatic logic [87:0] obs();
        return {id_valid,
                id_regwrite, id_memtoreg, id_mem_write, id_memread,
                id_ALUSrc, id_regdst, id_branch, id_jump,
                id_ALUOp, id_illegal,
                id_rs, id_rt, id_rd, id_shamt, id_function,
                id_pc_plus4, pc_write, ifid_write, stall_count};
    endfunction

    task automatic cyc(
        input string       nm,
        input logic        r,
        input logic [31:0] ins,
        input logic [31:0] pc4,
        input logic        v,
        input logic        fl,
        input logic        mr,
        input logic [4:0]  ert,
        input logic [87:0] e
    );
        exp_t x;
        rst         = r;
        if_instr    = ins;
        if_pc_plus4 = pc4;
        if_valid    = v;
        flush       = fl;
        ex_memread  = mr;
        ex_rt       = ert;
        x.nm = nm;
        x.e  = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        logic [87:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x   = sb.pop_front();
                got = obs();
                checks++;
                if (got !== x.e) begin
                    errors++;
                    $display("FAIL %s got=%h want=%h", x.nm, got, x.e);
                end
            end
        end
    end

    initial begin : driver
        int wait_cnt;
        rst         = 1'b1;
        if_instr    = 32'd0;
        if_pc_plus4 = 32'd0;
        if_valid    = 1'b0;
        flush       = 1'b0;
        ex_memread  = 1'b0;
        ex_rt       = 5'd0;
        @(posedge clk);
        #1;

        cyc("reset", 1, 32'h0, 32'h0, 0, 0, 0, 0,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 16'h0));
        cyc("post_reset", 0, 32'h8C220004, 32'h104, 1, 0, 0, 0,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 16'h0));
        cyc("lw_decode", 0, 32'h00430820, 32'h108, 1, 0, 0, 0,
            mk(1, C_LW, 2'b00, 0, 1, 2, 0, 0, 6'h04, 32'h104, 1, 1, 16'h0));
        cyc("load_use_stall", 0, 32'h20010005, 32'h10C, 1, 0, 1, 3,
            mk(1, 0, 0, 0, 2, 3, 1, 0, 6'h20, 32'h108, 0, 0, 16'h0));
        cyc("bubble_release", 0, 32'h20010005, 32'h10C, 1, 0, 1, 3,
            mk(1, C_R, 2'b10, 0, 2, 3, 1, 0, 6'h20, 32'h108, 1, 1, 16'h1));
        cyc("rt_zero_nostall", 0, 32'h00430820, 32'h110, 1, 0, 1, 0,
            mk(1, C_ADDI, 2'b00, 0, 0, 1, 0, 0, 6'h05, 32'h10C, 1, 1, 16'h1));
        cyc("flush_over_stall", 0, 32'h12345678, 32'h114, 1, 1, 1, 3,
            mk(1, C_R, 2'b10, 0, 2, 3, 1, 0, 6'h20, 32'h110, 1, 1, 16'h1));
        cyc("after_flush", 0, 32'hFC000000, 32'h118, 1, 0, 0, 0,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h110, 1, 1, 16'h1));
        cyc("illegal_op", 0, 32'hFC000000, 32'h11C, 0, 0, 0, 0,
            mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h118, 1, 1, 16'h1));
        cyc("invalid_word", 0, 32'h10220003, 32'h120, 1, 0, 0, 0,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11C, 1, 1, 16'h1));
        cyc("beq_rt_stall", 0, 32'hAC450008, 32'h124, 1, 0, 1, 2,
            mk(1, 0, 0, 0, 1, 2, 0, 0, 6'h03, 32'h120, 0, 0, 16'h1));
        cyc("beq_decode", 0, 32'hAC450008, 32'h124, 1, 0, 0, 0,
            mk(1, C_BEQ, 2'b01, 0, 1, 2, 0, 0, 6'h03, 32'h120, 1, 1, 16'h2));
        cyc("sw_rt_stall", 0, 32'h8C220004, 32'h128, 1, 0, 1, 5,
            mk(1, 0, 0, 0, 2, 5, 0, 0, 6'h08, 32'h124, 0, 0, 16'h2));
        cyc("sw_decode", 0, 32'h8C220004, 32'h128, 1, 0, 0, 0,
            mk(1, C_SW, 2'b00, 0, 2, 5, 0, 0, 6'h08, 32'h124, 1, 1, 16'h3));
        cyc("lw_rs_stall", 0, 32'h8C430000, 32'h12C, 1, 0, 1, 1,
            mk(1, 0, 0, 0, 1, 2, 0, 0, 6'h04, 32'h128, 0, 0, 16'h3));
        cyc("lw_after_bubble", 0, 32'h8C430000, 32'h12C, 1, 0, 0, 0,
            mk(1, C_LW, 2'b00, 0, 1, 2, 0, 0, 6'h04, 32'h128, 1, 1, 16'h4));
        cyc("lw_lw_stall", 0, 32'h20230007, 32'h130, 1, 0, 1, 2,
            mk(1, 0, 0, 0, 2, 3, 0, 0, 6'h00, 32'h12C, 0, 0, 16'h4));
        cyc("lw2_decode", 0, 32'h20230007, 32'h130, 1, 0, 0, 0,
            mk(1, C_LW, 2'b00, 0, 2, 3, 0, 0, 6'h00, 32'h12C, 1, 1, 16'h5));
        cyc("addi_rt_nostall", 0, 32'h08000010, 32'h134, 1, 0, 1, 3,
            mk(1, C_ADDI, 2'b00, 0, 1, 3, 0, 0, 6'h07, 32'h130, 1, 1, 16'h5));
        cyc("jump", 0, 32'h00430820, 32'h138, 1, 0, 0, 0,
            mk(1, C_J, 2'b00, 0, 0, 0, 0, 0, 6'h10, 32'h134, 1, 1, 16'h5));

        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;

        cyc("stall_fffe", 0, 32'h00430820, 32'h13C, 1, 0, 1, 3,
            mk(1, 0, 0, 0, 2, 3, 1, 0, 6'h20, 32'h138, 0, 0, 16'hFFFE));
        cyc("bubble_ffff", 0, 32'h00430820, 32'h13C, 1, 0, 1, 3,
            mk(1, C_R, 2'b10, 0, 2, 3, 1, 0, 6'h20, 32'h138, 1, 1, 16'hFFFF));
        cyc("stall_sat", 0, 32'h00430820, 32'h140, 1, 0, 1, 3,
            mk(1, 0, 0, 0, 2, 3, 1, 0, 6'h20, 32'h13C, 0, 0, 16'hFFFF));
        cyc("bubble_sat", 0, 32'h00430820, 32'h140, 1, 0, 1, 3,
            mk(1, C_R, 2'b10, 0, 2, 3, 1, 0, 6'h20, 32'h13C, 1, 1, 16'hFFFF));
        cyc("stall_again", 0, 32'h00430820, 32'h144, 1, 0, 1, 3,
            mk(1, 0, 0, 0, 2, 3, 1, 0, 6'h20, 32'h140, 0, 0, 16'hFFFF));
        cyc("reset_in_bubble", 1, 32'h00430820, 32'h144, 1, 0, 1, 3,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 16'h0));
        cyc("reset_release", 0, 32'h00430820, 32'h144, 1, 0, 1, 3,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 16'h0));
        cyc("post_reset_load", 0, 32'h0, 32'h148, 0, 0, 0, 0,
            mk(1, C_R, 2'b10, 0, 2, 3, 1, 0, 6'h20, 32'h144, 1, 1, 16'h0));

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 5) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
